// File: rtl/control_unit_p_if.sv
// Datapath-facing bundle of the microprogrammed control unit: instruction/status inputs,
// microword control bus and current microstate out.
interface control_unit_p_if;
  // No valid/ready handshake on this bus: ir and the status levels are sampled on every
  // rising clock edge, and ctl/state are registered outputs that stay valid for a whole cycle.
  logic [31:0] ir;
  logic        moc;
  logic        cond;
  logic        lsm_detect;
  logic        lsm_end;
  logic [33:0] ctl;
  logic [7:0]  state;

  modport master (
    output ir, moc, cond, lsm_detect, lsm_end,
    input  ctl, state
  );

  modport slave (
    input  ir, moc, cond, lsm_detect, lsm_end,
    output ctl, state
  );
endinterface

// File: rtl/control_unit_p.sv
// Microsequencer, 256-entry microstore and microword pipeline register for the ARM datapath.
module control_unit_p (
  input logic               clk,
  input logic               clr,
  control_unit_p_if.slave   bus
);

  // Microword pipeline register; bits 63:58 are always zero and are not stored.
  logic [57:0] q;
  logic [7:0]  inc;
  logic [7:0]  na;
  logic [7:0]  enc;
  logic [7:0]  jt;
  logic        sel;
  logic        sts;
  logic [63:0] rom_na_word;
  logic [63:0] rom_zero_word;

  wire [2:0] q_n   = q[57:55];
  wire       q_inv = q[54];
  wire       q_mi  = q[53];
  wire [2:0] q_s   = q[52:50];

  function automatic logic [63:0] builtin_word(input logic [7:0] a);
    logic [2:0]  n;
    logic        inv;
    logic [2:0]  s;
    logic [7:0]  t;
    logic [33:0] c;
    n   = 3'b001;
    inv = 1'b0;
    s   = 3'b000;
    t   = 8'd0;
    c   = '0;
    case (a)
      8'd0: n = 3'b011;
      8'd1: begin c[30] = 1'b1; c[28] = 1'b1; n = 3'b011; end
      // Memory read: hold in this state until MOC, then fall through to IR load.
      8'd2: begin c[29] = 1'b1; c[28] = 1'b1; c[27] = 1'b1; n = 3'b110; t = 8'd2; end
      8'd3: begin c[31] = 1'b1; n = 3'b011; end
      8'd4: begin s = 3'b001; inv = 1'b1; n = 3'b101; t = 8'd1; end
      8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16, 8'd17, 8'd19, 8'd21, 8'd22,
      8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd30, 8'd34, 8'd43,
      8'd44: begin n = 3'b010; t = 8'd1; end
      default: ;
    endcase
    return {6'b0, n, inv, 1'b0, s, a, t, c};
  endfunction

  assign rom_na_word   = builtin_word(na);
  assign rom_zero_word = builtin_word(8'd0);

  logic unused_rom_hi;
  logic unused_ir;
  assign unused_rom_hi = ^{rom_na_word[63:58], rom_zero_word[63:58]};
  assign unused_ir     = ^{bus.ir[31:28], bus.ir[19:8], bus.ir[6:5], bus.ir[3:0]};

  // Instruction encoder: maps IR class/addressing mode to the first execute microstate.
  always_comb begin
    enc = 8'd1;
    case (bus.ir[27:25])
      3'b000: begin
        // Compare/test ops with S set take priority over the shift-form split.
        if (bus.ir[24:23] == 2'b10 && bus.ir[20])      enc = 8'd14;
        else if (!bus.ir[4])                            enc = 8'd10;
        else if (!bus.ir[7])                            enc = 8'd12;
        else                                            enc = 8'd1;
      end
      3'b001: enc = (bus.ir[24:23] == 2'b10 && bus.ir[20]) ? 8'd15 : 8'd11;
      3'b010, 3'b011: begin
        case ({bus.ir[25], bus.ir[20]})
          2'b01: enc = !bus.ir[24] ? 8'd17 : (bus.ir[21] ? 8'd19 : 8'd16);
          2'b11: enc = !bus.ir[24] ? 8'd22 : (bus.ir[21] ? 8'd23 : 8'd21);
          2'b00: enc = !bus.ir[24] ? 8'd25 : (bus.ir[21] ? 8'd26 : 8'd24);
          default: enc = !bus.ir[24] ? 8'd28 : (bus.ir[21] ? 8'd29 : 8'd27);
        endcase
      end
      3'b100: enc = bus.ir[20] ? 8'd34 : 8'd30;
      3'b101: enc = bus.ir[24] ? 8'd44 : 8'd43;
      default: enc = 8'd1;
    endcase
  end

  always_comb begin
    case (q_s)
      3'b000:  sel = bus.moc;
      3'b001:  sel = bus.cond;
      3'b010:  sel = bus.lsm_detect;
      3'b011:  sel = bus.lsm_end;
      3'b100:  sel = bus.ir[24];
      default: sel = 1'b0;
    endcase
    sts = sel ^ q_inv;
    jt  = q_mi ? q[49:42] : q[41:34];
    case (q_n)
      3'b000:  na = enc;
      3'b001:  na = 8'd0;
      3'b010:  na = jt;
      3'b011:  na = inc;
      3'b100:  na = sts ? jt  : inc;
      3'b101:  na = sts ? jt  : enc;
      3'b110:  na = sts ? inc : jt;
      default: na = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q   <= rom_zero_word[57:0];
      inc <= 8'd1;
    end else begin
      q   <= rom_na_word[57:0];
      inc <= na + 8'd1;
    end
  end

  assign bus.ctl   = q[33:0];
  assign bus.state = q[49:42];

endmodule

// File: tb/tb_control_unit_p.sv
// Self-checking bench for control_unit_p: table-driven decode vectors plus MOC-wait and
// reset-during-wait sequences, checked through an expected-value queue.
module tb_control_unit_p;

  logic clk;
  logic clr;
  control_unit_p_if bus();

  control_unit_p dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic        cond;
    logic [7:0]  target;
  } vec_t;

  vec_t        vecs[$];
  logic [41:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  // Control bits each built-in microstate must drive.
  function automatic logic [33:0] ctl_of(input logic [7:0] st);
    logic [33:0] c;
    c = '0;
    case (st)
      8'd1: begin c[30] = 1'b1; c[28] = 1'b1; end
      8'd2: begin c[29] = 1'b1; c[28] = 1'b1; c[27] = 1'b1; end
      8'd3: c[31] = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic push(input logic [7:0] st);
    exp_q.push_back({ctl_of(st), st});
  endtask

  task automatic check(input string name);
    logic [41:0] act;
    logic [41:0] exp;
    act = {bus.ctl, bus.state};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected value queued, got ctl=%h state=%0d", name, act[41:8], act[7:0]);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got ctl=%h state=%0d, expected ctl=%h state=%0d",
                 name, act[41:8], act[7:0], exp[41:8], exp[7:0]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.lsm_detect = 1'($urandom_range(0, 1));
    bus.lsm_end    = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input string name);
    clr = 1'b1;
    push(8'd0);
    step();
    check(name);
    clr = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] after;
    do_reset($sformatf("vec%0d_reset", idx));
    bus.ir   = v.ir;
    bus.cond = v.cond;
    bus.moc  = 1'b1;
    after    = (v.target == 8'd1) ? 8'd2 : 8'd1;
    push(8'd1); push(8'd2); push(8'd3); push(8'd4); push(v.target); push(after);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("vec%0d_ir%h_step%0d", idx, v.ir, k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    clr            = 1'b1;
    bus.ir         = '0;
    bus.moc        = 1'b0;
    bus.cond       = 1'b0;
    bus.lsm_detect = 1'b0;
    bus.lsm_end    = 1'b0;

    vecs.push_back('{32'h0B000000, 1'b1, 8'd44});
    vecs.push_back('{32'h0A000000, 1'b1, 8'd43});
    vecs.push_back('{32'h08000000, 1'b1, 8'd30});
    vecs.push_back('{32'h08100000, 1'b1, 8'd34});
    vecs.push_back('{32'h05D00000, 1'b1, 8'd16});
    vecs.push_back('{32'h04500000, 1'b1, 8'd17});
    vecs.push_back('{32'h05F00000, 1'b1, 8'd19});
    vecs.push_back('{32'h07900000, 1'b1, 8'd21});
    vecs.push_back('{32'h06500000, 1'b1, 8'd22});
    vecs.push_back('{32'h07B00000, 1'b1, 8'd23});
    vecs.push_back('{32'h05800000, 1'b1, 8'd24});
    vecs.push_back('{32'h04000000, 1'b1, 8'd25});
    vecs.push_back('{32'h05A00000, 1'b1, 8'd26});
    vecs.push_back('{32'h07800000, 1'b1, 8'd27});
    vecs.push_back('{32'h06000000, 1'b1, 8'd28});
    vecs.push_back('{32'h07A00000, 1'b1, 8'd29});
    vecs.push_back('{32'hE1D45004, 1'b1, 8'd10});
    vecs.push_back('{32'hF29A102C, 1'b1, 8'd11});
    vecs.push_back('{32'hE0000010, 1'b1, 8'd12});
    vecs.push_back('{32'hE3500000, 1'b1, 8'd15});
    vecs.push_back('{32'hE0000090, 1'b1, 8'd1});
    vecs.push_back('{32'h0C000000, 1'b1, 8'd1});
    vecs.push_back('{32'h0B000000, 1'b0, 8'd1});
    vecs.push_back('{32'h05D00000, 1'b0, 8'd1});

    step();
    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // MOC held low: fetch stays in the memory-read state with MDRLd/MOV asserted.
    do_reset("wait_reset");
    bus.moc = 1'b0;
    bus.ir  = 32'(  $urandom_range(0, 32'h7FFFFFFF));
    push(8'd1);
    step(); check("wait_enter1");
    for (int k = 0; k < 12; k++) begin
      push(8'd2);
      step(); check($sformatf("wait_hold%0d", k));
    end
    bus.moc = 1'b1;
    push(8'd3);
    step(); check("wait_release");

    // Reset asserted mid-wait must override the hold and restart at address 1.
    do_reset("midwait_reset0");
    bus.moc = 1'b0;
    push(8'd1); step(); check("midwait_s1");
    push(8'd2); step(); check("midwait_s2");
    push(8'd2); step(); check("midwait_hold");
    clr = 1'b1;
    push(8'd0); step(); check("midwait_clr");
    clr = 1'b0;
    push(8'd1); step(); check("midwait_after1");
    push(8'd2); step(); check("midwait_after2");
    push(8'd2); step(); check("midwait_after_hold");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected values never compared", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
